// File: rtl/multi_light_manager.sv
// Multi-channel LED brightness manager with per-channel PWM and optional fade.
// Define MLM_FADE_EN to enable the ramped level fade; otherwise level tracks target.
module multi_light_manager #(
  parameter int N_CH     = 4,
  parameter int W        = 8,
  parameter int STEP     = 5,
  parameter int RAMP_DIV = 64,
  parameter int INIT_LVL = 0
) (
  input  logic                                   clk_i,
  input  logic                                   rst_n_i,
  input  logic                                   inc_i,
  input  logic                                   dec_i,
  input  logic                                   sel_i,
  output logic [N_CH-1:0]                        pwm_o,
  output logic [(N_CH>1?$clog2(N_CH):1)-1:0]     sel_o,
  output logic [W-1:0]                           level_o,
  output logic                                   busy_o
);

  localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [W:0]   STEPV = (W+1)'(STEP);
  localparam logic [W:0]   MAXV  = {1'b0, {W{1'b1}}};
  localparam logic [W-1:0] INITV = W'(INIT_LVL);
  localparam logic [SW-1:0] LAST = SW'(N_CH - 1);

  logic [W-1:0]  tgt     [N_CH];
  logic [W-1:0]  tgt_nxt [N_CH];
  logic [W-1:0]  lvl     [N_CH];
  logic [W-1:0]  lvl_nxt [N_CH];
  logic [SW-1:0] sel, sel_nxt;
  logic [W-1:0]  cnt;
  logic          busy_nxt;
  logic [W:0]    cur, sum, dif;
  logic [W-1:0]  inc_v, dec_v;

  // Step arithmetic is one bit wider so saturation compares never overflow.
  always_comb begin
    cur   = {1'b0, tgt[sel]};
    sum   = cur + STEPV;
    dif   = cur - STEPV;
    inc_v = (sum > MAXV) ? {W{1'b1}} : sum[W-1:0];
    dec_v = (cur < STEPV) ? '0 : dif[W-1:0];
    tgt_nxt = tgt;
    if (inc_i && !dec_i) begin
      tgt_nxt[sel] = inc_v;
    end else if (dec_i && !inc_i) begin
      tgt_nxt[sel] = dec_v;
    end
  end

  always_comb begin
    sel_nxt = sel;
    if (sel_i) begin
      sel_nxt = (sel == LAST) ? '0 : sel + 1'b1;
    end
  end

`ifdef MLM_FADE_EN
  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'(RAMP_DIV - 1);

  logic [PW-1:0] presc;
  logic          tick;

  assign tick = (presc == PLAST);

  always_comb begin
    lvl_nxt  = lvl;
    busy_nxt = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (tick) begin
        if (lvl[c] < tgt[c]) begin
          lvl_nxt[c] = lvl[c] + 1'b1;
        end else if (lvl[c] > tgt[c]) begin
          lvl_nxt[c] = lvl[c] - 1'b1;
        end
      end
      if (lvl_nxt[c] != tgt_nxt[c]) begin
        busy_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      presc <= '0;
      for (int c = 0; c < N_CH; c++) begin
        lvl[c] <= INITV;
      end
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      lvl   <= lvl_nxt;
    end
  end
`else
  assign lvl      = tgt;
  assign lvl_nxt  = tgt_nxt;
  assign busy_nxt = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int c = 0; c < N_CH; c++) begin
        tgt[c] <= INITV;
      end
      sel     <= '0;
      cnt     <= '0;
      pwm_o   <= '0;
      level_o <= INITV;
      busy_o  <= 1'b0;
    end else begin
      tgt     <= tgt_nxt;
      sel     <= sel_nxt;
      cnt     <= cnt + 1'b1;
      level_o <= lvl_nxt[sel_nxt];
      busy_o  <= busy_nxt;
      for (int c = 0; c < N_CH; c++) begin
        pwm_o[c] <= (cnt < lvl[c]);
      end
    end
  end

  assign sel_o = sel;

endmodule

// File: tb/tb_multi_light_manager.sv
// Directed self-checking bench for multi_light_manager.
// Covers both MLM_FADE_EN builds.
module tb_multi_light_manager;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inc = 1'b0;
  logic       dec = 1'b0;
  logic       sel = 1'b0;
  logic [2:0] pwm;
  logic [1:0] sel_q;
  logic [7:0] level;
  logic       busy;

  int checks = 0;
  int fails  = 0;

  multi_light_manager #(
    .N_CH(3), .W(8), .STEP(5), .RAMP_DIV(4), .INIT_LVL(0)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .inc_i(inc), .dec_i(dec),
    .sel_i(sel), .pwm_o(pwm), .sel_o(sel_q), .level_o(level),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    #2 rst_n = 1'b0;
    inc = 1'b0; dec = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse(input logic i, input logic d, input logic s);
    inc = i; dec = d; sel = s;
    @(negedge clk);
    inc = 1'b0; dec = 1'b0; sel = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_settle(input string nm);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s settle: busy=%b after %0d cycles, required 0", nm, busy, n);
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    do_reset();
    for (int k = 0; k < 1000; k++) begin
      if (pwm !== 3'b000 || sel_q !== 2'd0 || level !== 8'd0 || busy !== 1'b0)
        bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL reset_idle: %0d nonzero cycles, required 0", bad);
    end
    checks++;
    if ({pwm, sel_q, level, busy} !== 14'd0) begin
      fails++;
      $display("FAIL reset_vals: pwm=%b sel=%0d lvl=%0d busy=%b, required 0",
               pwm, sel_q, level, busy);
    end
  endtask

  task automatic test_fade();
    int n = 0;
    int hi = 0;
    int other = 0;
    do_reset();
    pulse(1, 0, 0);
    pulse(1, 0, 0);
`ifdef MLM_FADE_EN
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL fade_busy: busy=%b, required 1", busy);
    end
    while (level !== 8'd10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n + 4 < 36 || n + 4 > 46) begin
      fails++;
      $display("FAIL fade_time: reached 10 after %0d cycles, required 36..46", n + 4);
    end
    @(negedge clk);
`endif
    checks++;
    if (level !== 8'd10 || busy !== 1'b0) begin
      fails++;
      $display("FAIL fade_end: lvl=%0d busy=%b, required 10 0", level, busy);
    end
    for (int k = 0; k < 256; k++) begin
      if (pwm[0]) hi++;
      if (pwm[2:1] != 2'b00) other++;
      @(negedge clk);
    end
    checks++;
    if (hi != 10) begin
      fails++;
      $display("FAIL pwm_duty: high %0d of 256, required 10", hi);
    end
    checks++;
    if (other != 0) begin
      fails++;
      $display("FAIL pwm_idle: ch1/ch2 high %0d cycles, required 0", other);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    repeat (50) pulse(1, 0, 0);
    wait_settle("sat50");
    checks++;
    if (level !== 8'd250) begin
      fails++;
      $display("FAIL inc50: lvl=%0d, required 250", level);
    end
    repeat (2) pulse(1, 0, 0);
    wait_settle("sat52");
    checks++;
    if (level !== 8'd255) begin
      fails++;
      $display("FAIL inc_sat: lvl=%0d, required 255", level);
    end
    pulse(1, 0, 0);
    checks++;
    if (level !== 8'd255 || busy !== 1'b0) begin
      fails++;
      $display("FAIL inc_hold: lvl=%0d busy=%b, required 255 0", level, busy);
    end
    repeat (52) pulse(0, 1, 0);
    wait_settle("dec52");
    checks++;
    if (level !== 8'd0) begin
      fails++;
      $display("FAIL dec_floor: lvl=%0d, required 0", level);
    end
    pulse(0, 1, 0);
    checks++;
    if (level !== 8'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL dec_hold: lvl=%0d busy=%b, required 0 0", level, busy);
    end
  endtask

  task automatic test_select();
    logic [1:0] exp_s [3];
    exp_s[0] = 2'd1; exp_s[1] = 2'd2; exp_s[2] = 2'd0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      pulse(0, 0, 1);
      checks++;
      if (sel_q !== exp_s[k]) begin
        fails++;
        $display("FAIL sel_step%0d: sel=%0d, required %0d", k, sel_q, exp_s[k]);
      end
    end
    pulse(1, 0, 1);
    checks++;
    if (sel_q !== 2'd1 || level !== 8'd0) begin
      fails++;
      $display("FAIL sel_inc: sel=%0d lvl=%0d, required 1 0", sel_q, level);
    end
    pulse(0, 0, 1);
    pulse(0, 0, 1);
    wait_settle("sel_back");
    checks++;
    if (sel_q !== 2'd0 || level !== 8'd5) begin
      fails++;
      $display("FAIL sel_old_ch: sel=%0d lvl=%0d, required 0 5", sel_q, level);
    end
    pulse(1, 1, 0);
    checks++;
    if (level !== 8'd5 || busy !== 1'b0) begin
      fails++;
      $display("FAIL inc_dec: lvl=%0d busy=%b, required 5 0", level, busy);
    end
    inc = 1'b1;
    repeat (3) @(negedge clk);
    inc = 1'b0;
    wait_settle("wide");
    checks++;
    if (level !== 8'd20) begin
      fails++;
      $display("FAIL wide_pulse: lvl=%0d, required 20", level);
    end
  endtask

  task automatic test_retarget();
    int n = 0;
    int mx = 0;
    int mn_after = 255;
    logic seen = 1'b0;
    do_reset();
    pulse(0, 0, 1);
    repeat (20) pulse(1, 0, 0);
    while (level < 8'd50 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    pulse(0, 1, 0);
    n = 0;
    while ((busy || n < 8) && n < 3000) begin
      if (int'(level) > mx) mx = int'(level);
      if (level == 8'd95) seen = 1'b1;
      if (seen && int'(level) < mn_after) mn_after = int'(level);
      @(negedge clk);
      n++;
    end
    checks++;
    if (mx > 100) begin
      fails++;
      $display("FAIL retgt_peak: peak=%0d, required <=100", mx);
    end
    checks++;
    if (level !== 8'd95 || busy !== 1'b0) begin
      fails++;
      $display("FAIL retgt_end: lvl=%0d busy=%b, required 95 0", level, busy);
    end
    checks++;
    if (mn_after < 95) begin
      fails++;
      $display("FAIL retgt_under: min=%0d, required >=95", mn_after);
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    do_reset();
    repeat (8) pulse(1, 0, 0);
`ifdef MLM_FADE_EN
    while (level !== 8'd37 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (level !== 8'd37 || busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_fade: lvl=%0d busy=%b, required 37 1", level, busy);
    end
`else
    checks++;
    if (level !== 8'd40) begin
      fails++;
      $display("FAIL pre_rst: lvl=%0d, required 40", level);
    end
`endif
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pwm, sel_q, level, busy} !== 14'd0) begin
      fails++;
      $display("FAIL async_rst: pwm=%b sel=%0d lvl=%0d busy=%b, required 0",
               pwm, sel_q, level, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`ifndef MLM_FADE_EN
    inc = 1'b1;
    @(negedge clk);
    inc = 1'b0;
    checks++;
    if (level !== 8'd5 || busy !== 1'b0) begin
      fails++;
      $display("FAIL nofade_next: lvl=%0d busy=%b, required 5 0", level, busy);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_fade();
    test_saturate();
    test_select();
    test_retarget();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
